// File: rtl/vote_pkg.sv
// Shared session/grant state encodings and ballot helpers for the vote booth scheduler.
package vote_pkg;

    localparam int unsigned NUM_CANDS_DEF = 4;
    localparam int unsigned MAX_CANDS     = 32;

    typedef enum logic [1:0] {
        SESS_IDLE   = 2'b00,
        SESS_OPEN   = 2'b01,
        SESS_CLOSED = 2'b10
    } sess_e;

    typedef enum logic [1:0] {
        GNT_ARB   = 2'b00,
        GNT_ISSUE = 2'b01,
        GNT_RESP  = 2'b10
    } gnt_e;

    function automatic logic is_onehot(input logic [MAX_CANDS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/vote_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module vote_rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] gnt_idx_o,
    output logic          gnt_vld_o
);

    logic [PW-1:0] idx;

    always_comb begin
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PW'((32'(ptr_i) + k) % N);
            if (!gnt_vld_o && req_i[idx]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = idx;
            end
        end
    end

endmodule

// File: rtl/vote_booth_scheduler.sv
// Session controller and round-robin booth arbiter in front of the vote tally.
// Define AUTO_CLOSE_EN to close the session automatically once every booth has voted.
module vote_booth_scheduler
    import vote_pkg::*;
#(
    parameter int unsigned NUM_BOOTHS     = 4,
    parameter int unsigned NUM_CANDS      = NUM_CANDS_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            open_req,
    input  logic                            close_req,
    input  logic [NUM_BOOTHS-1:0]           booth_req,
    input  logic [NUM_BOOTHS*NUM_CANDS-1:0] booth_cand,
    output logic [NUM_BOOTHS-1:0]           booth_ack,
    output logic [NUM_BOOTHS-1:0]           booth_nak,
    output logic                            tally_valid,
    output logic [NUM_CANDS-1:0]            tally_cand,
    input  logic                            tally_ready,
    output logic [1:0]                      session_state,
    output logic [3:0]                      votes_cast,
    output logic [NUM_BOOTHS-1:0]           voted_mask,
    output logic                            timeout_err
);

    localparam int unsigned PW = $clog2(NUM_BOOTHS);

    sess_e                 sess_q, sess_d;
    gnt_e                  gst_q, gst_d;
    logic [PW-1:0]         rr_q, rr_d, cur_q, cur_d;
    logic [7:0]            tmo_q, tmo_d;
    logic                  close_pend_q, close_pend_d;
    logic                  valid_q, valid_d;
    logic [NUM_CANDS-1:0]  cand_q, cand_d;
    logic [NUM_BOOTHS-1:0] ack_q, ack_d, nak_q, nak_d, voted_q, voted_d;
    logic [3:0]            votes_q, votes_d;
    logic                  terr_q, terr_d;

    logic [NUM_BOOTHS-1:0] req_eff;
    logic [PW-1:0]         rr_idx, low_idx;
    logic                  rr_vld, low_vld;
    logic [NUM_CANDS-1:0]  win_cand;
    logic                  win_ok, auto_close, close_now;

    // A booth still shows req during its own ack/nak cycle; don't serve it twice.
    assign req_eff = booth_req & ~(ack_q | nak_q);

    vote_rr_arbiter #(.N(NUM_BOOTHS), .PW(PW)) u_rr (
        .req_i    (req_eff),
        .ptr_i    (rr_q),
        .gnt_idx_o(rr_idx),
        .gnt_vld_o(rr_vld)
    );

    vote_rr_arbiter #(.N(NUM_BOOTHS), .PW(PW)) u_low (
        .req_i    (req_eff),
        .ptr_i    ('0),
        .gnt_idx_o(low_idx),
        .gnt_vld_o(low_vld)
    );

    assign win_cand = booth_cand[rr_idx*NUM_CANDS +: NUM_CANDS];
    assign win_ok   = is_onehot(MAX_CANDS'(win_cand)) && !voted_q[rr_idx];

`ifdef AUTO_CLOSE_EN
    assign auto_close = &voted_q;
`else
    assign auto_close = 1'b0;
`endif

    assign close_now = close_req | close_pend_q | auto_close;

    always_comb begin
        sess_d       = sess_q;
        gst_d        = gst_q;
        rr_d         = rr_q;
        cur_d        = cur_q;
        tmo_d        = tmo_q;
        close_pend_d = close_pend_q;
        valid_d      = valid_q;
        cand_d       = cand_q;
        ack_d        = '0;
        nak_d        = '0;
        voted_d      = voted_q;
        votes_d      = votes_q;
        terr_d       = terr_q;

        case (gst_q)
            GNT_ARB: begin
                if (sess_q == SESS_OPEN) begin
                    if (!close_now && rr_vld) begin
                        rr_d = (32'(rr_idx) == NUM_BOOTHS - 1) ? '0 : rr_idx + 1'b1;
                        if (win_ok) begin
                            cand_d  = win_cand;
                            valid_d = 1'b1;
                            cur_d   = rr_idx;
                            tmo_d   = '0;
                            gst_d   = GNT_ISSUE;
                        end else begin
                            nak_d[rr_idx] = 1'b1;
                        end
                    end
                end else if (low_vld) begin
                    nak_d[low_idx] = 1'b1;
                end
            end
            GNT_ISSUE: begin
                if (close_req) close_pend_d = 1'b1;
                if (tally_ready) begin
                    valid_d        = 1'b0;
                    ack_d[cur_q]   = 1'b1;
                    voted_d[cur_q] = 1'b1;
                    votes_d        = (votes_q == 4'hF) ? 4'hF : votes_q + 4'd1;
                    gst_d          = GNT_RESP;
                end else if (tmo_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    valid_d      = 1'b0;
                    nak_d[cur_q] = 1'b1;
                    terr_d       = 1'b1;
                    gst_d        = GNT_RESP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: gst_d = GNT_ARB;
        endcase

        case (sess_q)
            SESS_IDLE: begin
                if (open_req) begin
                    sess_d       = SESS_OPEN;
                    voted_d      = '0;
                    votes_d      = '0;
                    terr_d       = 1'b0;
                    close_pend_d = 1'b0;
                end
            end
            SESS_OPEN: begin
                // Closing waits for any in-flight ballot to resolve.
                if (close_now && gst_q != GNT_ISSUE) begin
                    sess_d       = SESS_CLOSED;
                    close_pend_d = 1'b0;
                end
            end
            SESS_CLOSED: begin
                if (!open_req && !close_req) sess_d = SESS_IDLE;
            end
            default: sess_d = SESS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sess_q       <= SESS_IDLE;
            gst_q        <= GNT_ARB;
            rr_q         <= '0;
            cur_q        <= '0;
            tmo_q        <= '0;
            close_pend_q <= 1'b0;
            valid_q      <= 1'b0;
            cand_q       <= '0;
            ack_q        <= '0;
            nak_q        <= '0;
            voted_q      <= '0;
            votes_q      <= '0;
            terr_q       <= 1'b0;
        end else begin
            sess_q       <= sess_d;
            gst_q        <= gst_d;
            rr_q         <= rr_d;
            cur_q        <= cur_d;
            tmo_q        <= tmo_d;
            close_pend_q <= close_pend_d;
            valid_q      <= valid_d;
            cand_q       <= cand_d;
            ack_q        <= ack_d;
            nak_q        <= nak_d;
            voted_q      <= voted_d;
            votes_q      <= votes_d;
            terr_q       <= terr_d;
        end
    end

    assign booth_ack     = ack_q;
    assign booth_nak     = nak_q;
    assign tally_valid   = valid_q;
    assign tally_cand    = cand_q;
    assign session_state = sess_q;
    assign votes_cast    = votes_q;
    assign voted_mask    = voted_q;
    assign timeout_err   = terr_q;

endmodule
